usb_rx_pkt_ctrl: RTL and testbench
==================================

USB_RX_PKT_CTRL -- requirements
Module: usb_rx_pkt_ctrl

Interface
REQ-001 SHALL have a parameter MAX_BYTES, default 66, giving the maximum post-PID bytes in a data packet (64 payload plus 2 CRC).
REQ-002 SHALL have the following ports, clock and reset first:
- clk, in, 1: system clock; single clock domain.
- n_rst, in, 1: asynchronous, active-low reset.
- start_detect, in, 1: one-cycle pulse from the edge detector at the first K on an idle bus.
- byte_ready, in, 1: one-cycle pulse; rcv_data holds a complete decoded byte.
- rcv_data, in, 8: decoded byte, LSB first on the wire.
- eop, in, 1: SE0 detected, held high while SE0 persists.
- rcving, out, 1: packet reception in progress.
- rx_packet, out, 3: packet-type and status code.
- rx_packet_data, out, 8: registered data byte.
- store_rx_packet_data, out, 1: one-cycle store strobe to the endpoint buffer.
- rx_byte_count, out, 7: data bytes stored in the current packet.
- rx_error, out, 1: sticky error flag for the current packet.

Function
REQ-003 rx_packet encoding SHALL be: 000 NONE, 001 IN, 010 OUT, 011 ACK, 100 NAK, 101 DATA0, 110 DATA1, 111 ERROR.
REQ-004 The FSM SHALL have the states IDLE, SYNC, PID, TOK1, TOK2, DATA, HSK_EOP, WAIT_EOP, DONE and ERR.
REQ-005 IDLE SHALL go to SYNC on start_detect; rcving SHALL assert in the cycle after start_detect.
REQ-006 SYNC SHALL go to PID on byte_ready with rcv_data==8'h80; any other byte, or eop, SHALL go to ERR.
REQ-007 PID state SHALL decode the PID byte on byte_ready:
- 8'hE1 (OUT) or 8'h69 (IN): go to TOK1.
- 8'hD2 (ACK) or 8'h5A (NAK): go to HSK_EOP.
- 8'hC3 (DATA0) or 8'h4B (DATA1): go to DATA.
- Any other value, including a failed complement check: go to ERR.
- eop: go to ERR.
REQ-008 rx_packet SHALL update in the cycle after the PID byte_ready and SHALL hold until the next start_detect or until ERROR is set.
REQ-009 TOK1 SHALL go to TOK2 on byte_ready, and TOK2 SHALL go to WAIT_EOP on byte_ready; eop in either state SHALL go to ERR; token bytes SHALL NOT be stored.
REQ-010 HSK_EOP SHALL go to DONE on eop; byte_ready before eop SHALL go to ERR.
REQ-011 In DATA, each byte_ready SHALL register rcv_data into rx_packet_data and pulse store_rx_packet_data high for exactly one cycle, one cycle later.
REQ-012 Each store in DATA SHALL increment rx_byte_count.
REQ-013 DATA SHALL go to DONE on eop when rx_byte_count>=2; eop with rx_byte_count<2 SHALL go to ERR.
REQ-014 A byte_ready in DATA that would make rx_byte_count exceed MAX_BYTES SHALL go to ERR without storing.
REQ-015 WAIT_EOP SHALL go to DONE on eop; byte_ready SHALL go to ERR.
REQ-016 DONE SHALL hold for one cycle, deassert rcving, and go to IDLE.
REQ-017 ERR SHALL set rx_error and rx_packet=111, and SHALL stay in ERR until eop is seen and then released; it SHALL then return to IDLE with rcving low.
REQ-018 rx_error and rx_packet SHALL hold until the next start_detect, which SHALL clear rx_error and rx_byte_count.
REQ-019 If byte_ready and eop assert in the same cycle, byte_ready SHALL be processed first and eop evaluated in the following state.
REQ-020 start_detect SHALL be ignored outside IDLE.
REQ-021 store_rx_packet_data SHALL never assert outside DATA.

Reset
REQ-022 On n_rst low, asynchronously, the block SHALL apply these values:
- State: IDLE.
- Outputs: rcving=0, rx_packet=000, rx_packet_data=8'h00, store_rx_packet_data=0, rx_byte_count=0, rx_error=0.
REQ-023 A reset in mid-packet SHALL abandon the packet with no further store strobes.

Structure
REQ-024 Package usb_rx_pkg SHALL hold:
- the state enum;
- the rx_packet code constants;
- the PID byte constants;
- the sync constant 8'h80.
REQ-025 Byte counting SHALL use one flex_counter instance (NUM_CNT_BITS=7) with clear on start_detect and count_enable on store; all other logic SHALL be in-module.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- OUT token: sync 80, E1, 00, 29, eop -> rx_packet=010 one cycle after PID; no stores; DONE then rcving=0; rx_error=0.
- DATA0: sync, C3, AA, AF, FF, E8, eop -> four store pulses carrying AA, AF, FF, E8 in order; rx_byte_count=4; rx_packet=101.
- ACK: sync, D2, eop -> rx_packet=011, zero stores; a stray byte before eop -> rx_packet=111, rx_error=1.
- Bad sync 88 -> ERR; rcving stays high until eop, then IDLE; next valid packet clears rx_error.
- Premature eop after E1 and one token byte -> rx_packet=111; DATA1 (4B) with 67 bytes -> 66 stores then error.
- n_rst asserted mid-DATA -> all outputs at reset values immediately; no store afterwards.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive packet controller.
// Holds the FSM state enum, rx_packet codes, PID/sync bytes and the PID decoder.
package usb_rx_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SYNC,
      ST_PID,
      ST_TOK1,
      ST_TOK2,
      ST_DATA,
      ST_HSK_EOP,
      ST_WAIT_EOP,
      ST_DONE,
      ST_ERR
   } rx_state_t;

   localparam logic [2:0] PKT_NONE  = 3'b000;
   localparam logic [2:0] PKT_IN    = 3'b001;
   localparam logic [2:0] PKT_OUT   = 3'b010;
   localparam logic [2:0] PKT_ACK   = 3'b011;
   localparam logic [2:0] PKT_NAK   = 3'b100;
   localparam logic [2:0] PKT_DATA0 = 3'b101;
   localparam logic [2:0] PKT_DATA1 = 3'b110;
   localparam logic [2:0] PKT_ERROR = 3'b111;

   localparam logic [7:0] PID_OUT   = 8'hE1;
   localparam logic [7:0] PID_IN    = 8'h69;
   localparam logic [7:0] PID_ACK   = 8'hD2;
   localparam logic [7:0] PID_NAK   = 8'h5A;
   localparam logic [7:0] PID_DATA0 = 8'hC3;
   localparam logic [7:0] PID_DATA1 = 8'h4B;

   localparam logic [7:0] SYNC_BYTE = 8'h80;

   // Only exact PID byte values are accepted, so a bad complement nibble falls to ERROR.
   function automatic logic [2:0] pid_to_pkt(input logic [7:0] pid);
      case (pid)
         PID_OUT:   return PKT_OUT;
         PID_IN:    return PKT_IN;
         PID_ACK:   return PKT_ACK;
         PID_NAK:   return PKT_NAK;
         PID_DATA0: return PKT_DATA0;
         PID_DATA1: return PKT_DATA1;
         default:   return PKT_ERROR;
      endcase
   endfunction

endpackage

// File: rtl/flex_counter.sv
// Parameterised up-counter with synchronous clear and count enable.
module flex_counter #(
   parameter int NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    clear,
   input  logic                    count_enable,
   output logic [NUM_CNT_BITS-1:0] count_out
);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         count_out <= '0;
      else if (clear)
         count_out <= '0;
      else if (count_enable)
         count_out <= count_out + 1'b1;
   end

endmodule

// File: rtl/usb_rx_pkt_ctrl.sv
// USB receive packet controller: walks SYNC/PID/token/data/handshake bytes,
// strobes data bytes to the endpoint buffer and reports packet type and errors.
module usb_rx_pkt_ctrl
   import usb_rx_pkg::*;
#(
   parameter int MAX_BYTES = 66
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       start_detect,
   input  logic       byte_ready,
   input  logic [7:0] rcv_data,
   input  logic       eop,
   output logic       rcving,
   output logic [2:0] rx_packet,
   output logic [7:0] rx_packet_data,
   output logic       store_rx_packet_data,
   output logic [6:0] rx_byte_count,
   output logic       rx_error
);

   localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);

   rx_state_t  state, state_nxt;
   logic [2:0] pkt_nxt;
   logic       err_nxt;
   logic       err_eop, err_eop_nxt;
   logic       store_now;
   logic       cnt_clear;

   // Byte-priority rule: in every state byte_ready is handled before eop.
   always_comb begin
      state_nxt = state;
      pkt_nxt   = rx_packet;
      err_nxt   = rx_error;
      store_now = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start_detect) begin
               state_nxt = ST_SYNC;
               pkt_nxt   = PKT_NONE;
               err_nxt   = 1'b0;
            end
         end
         ST_SYNC: begin
            if (byte_ready)
               state_nxt = (rcv_data == SYNC_BYTE) ? ST_PID : ST_ERR;
            else if (eop)
               state_nxt = ST_ERR;
         end
         ST_PID: begin
            if (byte_ready) begin
               pkt_nxt = pid_to_pkt(rcv_data);
               case (pid_to_pkt(rcv_data))
                  PKT_OUT, PKT_IN:     state_nxt = ST_TOK1;
                  PKT_ACK, PKT_NAK:    state_nxt = ST_HSK_EOP;
                  PKT_DATA0, PKT_DATA1: state_nxt = ST_DATA;
                  default:             state_nxt = ST_ERR;
               endcase
            end else if (eop)
               state_nxt = ST_ERR;
         end
         ST_TOK1: begin
            if (byte_ready)
               state_nxt = ST_TOK2;
            else if (eop)
               state_nxt = ST_ERR;
         end
         ST_TOK2: begin
            if (byte_ready)
               state_nxt = ST_WAIT_EOP;
            else if (eop)
               state_nxt = ST_ERR;
         end
         ST_DATA: begin
            if (byte_ready) begin
               if (rx_byte_count >= MAX_CNT)
                  state_nxt = ST_ERR;
               else
                  store_now = 1'b1;
            end else if (eop)
               state_nxt = (rx_byte_count >= 7'd2) ? ST_DONE : ST_ERR;
         end
         ST_HSK_EOP, ST_WAIT_EOP: begin
            if (byte_ready)
               state_nxt = ST_ERR;
            else if (eop)
               state_nxt = ST_DONE;
         end
         ST_DONE:
            state_nxt = ST_IDLE;
         ST_ERR: begin
            if (err_eop && !eop)
               state_nxt = ST_IDLE;
         end
         default:
            state_nxt = ST_IDLE;
      endcase
      if (state_nxt == ST_ERR) begin
         err_nxt = 1'b1;
         pkt_nxt = PKT_ERROR;
      end
   end

   // ERR leaves only after eop has been seen and then released.
   assign err_eop_nxt = (state == ST_ERR) && (err_eop || eop);
   assign cnt_clear   = (state == ST_IDLE) && start_detect;
   assign rcving      = (state != ST_IDLE) && (state != ST_DONE);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state                <= ST_IDLE;
         rx_packet            <= PKT_NONE;
         rx_error             <= 1'b0;
         rx_packet_data       <= 8'h00;
         store_rx_packet_data <= 1'b0;
         err_eop              <= 1'b0;
      end else begin
         state                <= state_nxt;
         rx_packet            <= pkt_nxt;
         rx_error             <= err_nxt;
         store_rx_packet_data <= store_now;
         err_eop              <= err_eop_nxt;
         if (store_now)
            rx_packet_data <= rcv_data;
      end
   end

   flex_counter #(
      .NUM_CNT_BITS(7)
   ) u_byte_cnt (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (cnt_clear),
      .count_enable (store_now),
      .count_out    (rx_byte_count)
   );

endmodule

// File: tb/tb_usb_rx_pkt_ctrl.sv
// Directed bench for usb_rx_pkt_ctrl: token, data, handshake, error and reset scenarios.
module tb_usb_rx_pkt_ctrl;

   logic       tb_clk;
   logic       n_rst;
   logic       start_detect;
   logic       byte_ready;
   logic [7:0] rcv_data;
   logic       eop;
   logic       rcving;
   logic [2:0] rx_packet;
   logic [7:0] rx_packet_data;
   logic       store_rx_packet_data;
   logic [6:0] rx_byte_count;
   logic       rx_error;

   int         n_vec = 0;
   int         n_err = 0;
   int         store_cnt = 0;
   int         s0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_b;
   logic [7:0] rnd_b;

   usb_rx_pkt_ctrl #(.MAX_BYTES(66)) dut (
      .clk                  (tb_clk),
      .n_rst                (n_rst),
      .start_detect         (start_detect),
      .byte_ready           (byte_ready),
      .rcv_data             (rcv_data),
      .eop                  (eop),
      .rcving               (rcving),
      .rx_packet            (rx_packet),
      .rx_packet_data       (rx_packet_data),
      .store_rx_packet_data (store_rx_packet_data),
      .rx_byte_count        (rx_byte_count),
      .rx_error             (rx_error)
   );

   // clock / reset
   initial tb_clk = 1'b0;
   always #5 tb_clk = ~tb_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // driver tasks: inputs change #1 after the rising edge
   task automatic cycle();
      @(posedge tb_clk);
      #1;
   endtask

   task automatic send_start();
      start_detect = 1'b1;
      cycle();
      start_detect = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rcv_data   = b;
      byte_ready = 1'b1;
      cycle();
      byte_ready = 1'b0;
   endtask

   task automatic drive_eop(input int n);
      eop = 1'b1;
      repeat (n) cycle();
      eop = 1'b0;
      cycle();
   endtask

   // scoreboard: every store strobe must match the next expected byte
   always @(negedge tb_clk) begin
      if (store_rx_packet_data) begin
         store_cnt++;
         if (exp_q.size() == 0)
            check("unexpected_store", 32'(store_rx_packet_data), 32'd0);
         else begin
            exp_b = exp_q.pop_front();
            check("store_data", 32'(rx_packet_data), 32'(exp_b));
         end
      end
   end

   initial begin
      n_rst = 1'b0; start_detect = 1'b0; byte_ready = 1'b0; rcv_data = 8'h00; eop = 1'b0;
      #12;
      check("rst_rcving", 32'(rcving), 0);
      check("rst_pkt",    32'(rx_packet), 0);
      check("rst_data",   32'(rx_packet_data), 0);
      check("rst_store",  32'(store_rx_packet_data), 0);
      check("rst_count",  32'(rx_byte_count), 0);
      check("rst_error",  32'(rx_error), 0);
      n_rst = 1'b1;
      cycle();

      // OUT token
      s0 = store_cnt;
      send_start();
      check("out_rcving", 32'(rcving), 1);
      send_byte(8'h80);
      send_byte(8'hE1);
      check("out_pkt", 32'(rx_packet), 32'(3'b010));
      send_byte(8'h00);
      send_byte(8'h29);
      eop = 1'b1;
      cycle();
      check("out_done_rcving", 32'(rcving), 0);
      cycle();
      eop = 1'b0;
      cycle();
      check("out_idle_rcving", 32'(rcving), 0);
      check("out_error", 32'(rx_error), 0);
      check("out_stores", 32'(store_cnt - s0), 0);

      // DATA0 with four bytes
      s0 = store_cnt;
      send_start();
      send_byte(8'h80);
      send_byte(8'hC3);
      check("d0_pkt", 32'(rx_packet), 32'(3'b101));
      exp_q.push_back(8'hAA); send_byte(8'hAA);
      exp_q.push_back(8'hAF); send_byte(8'hAF);
      exp_q.push_back(8'hFF); send_byte(8'hFF);
      exp_q.push_back(8'hE8); send_byte(8'hE8);
      drive_eop(2);
      check("d0_count", 32'(rx_byte_count), 4);
      check("d0_stores", 32'(store_cnt - s0), 4);
      check("d0_error", 32'(rx_error), 0);
      check("d0_pkt_hold", 32'(rx_packet), 32'(3'b101));

      // ACK handshake, then ACK with a stray byte
      s0 = store_cnt;
      send_start();
      send_byte(8'h80);
      send_byte(8'hD2);
      check("ack_pkt", 32'(rx_packet), 32'(3'b011));
      drive_eop(2);
      check("ack_rcving", 32'(rcving), 0);
      check("ack_error", 32'(rx_error), 0);
      check("ack_stores", 32'(store_cnt - s0), 0);
      send_start();
      check("ack2_err_clr", 32'(rx_error), 0);
      send_byte(8'h80);
      send_byte(8'hD2);
      send_byte(8'h5A);
      check("ack_stray_pkt", 32'(rx_packet), 32'(3'b111));
      check("ack_stray_err", 32'(rx_error), 1);
      drive_eop(2);
      check("ack_stray_rcving", 32'(rcving), 0);

      // bad sync: stay in ERR until eop, next packet clears error
      send_start();
      send_byte(8'h88);
      check("bsync_err", 32'(rx_error), 1);
      check("bsync_pkt", 32'(rx_packet), 32'(3'b111));
      repeat (3) cycle();
      check("bsync_hold_rcving", 32'(rcving), 1);
      drive_eop(2);
      check("bsync_rel_rcving", 32'(rcving), 0);
      check("bsync_err_hold", 32'(rx_error), 1);
      send_start();
      check("bsync_err_clr", 32'(rx_error), 0);
      check("bsync_cnt_clr", 32'(rx_byte_count), 0);
      send_byte(8'h80);
      send_byte(8'hC3);
      exp_q.push_back(8'h12); send_byte(8'h12);
      // last byte arrives together with eop: byte stored first
      exp_q.push_back(8'h34);
      eop = 1'b1;
      send_byte(8'h34);
      drive_eop(1);
      check("same_cyc_count", 32'(rx_byte_count), 2);
      check("same_cyc_err", 32'(rx_error), 0);
      check("same_cyc_pkt", 32'(rx_packet), 32'(3'b101));

      // premature eop in a token
      send_start();
      send_byte(8'h80);
      send_byte(8'hE1);
      send_byte(8'h00);
      eop = 1'b1;
      cycle();
      check("tok_eop_pkt", 32'(rx_packet), 32'(3'b111));
      check("tok_eop_err", 32'(rx_error), 1);
      drive_eop(1);

      // DATA with a single byte then eop: too short
      send_start();
      send_byte(8'h80);
      send_byte(8'hC3);
      exp_q.push_back(8'h11); send_byte(8'h11);
      eop = 1'b1;
      cycle();
      check("short_err", 32'(rx_error), 1);
      drive_eop(1);

      // DATA1 with 67 bytes: 66 stored, the 67th errors
      s0 = store_cnt;
      send_start();
      send_byte(8'h80);
      send_byte(8'h4B);
      check("d1_pkt", 32'(rx_packet), 32'(3'b110));
      for (int i = 0; i < 66; i++) begin
         rnd_b = 8'($urandom_range(0, 255));
         exp_q.push_back(rnd_b);
         send_byte(rnd_b);
      end
      check("d1_count66", 32'(rx_byte_count), 66);
      check("d1_err_before", 32'(rx_error), 0);
      send_byte(8'h5C);
      check("d1_ovf_err", 32'(rx_error), 1);
      check("d1_ovf_pkt", 32'(rx_packet), 32'(3'b111));
      repeat (2) cycle();
      check("d1_ovf_count", 32'(rx_byte_count), 66);
      check("d1_stores", 32'(store_cnt - s0), 66);
      drive_eop(2);

      // reset in the middle of a DATA packet
      send_start();
      send_byte(8'h80);
      send_byte(8'hC3);
      exp_q.push_back(8'h01); send_byte(8'h01);
      send_byte(8'h02);
      n_rst = 1'b0;
      #1;
      s0 = store_cnt;
      check("mrst_rcving", 32'(rcving), 0);
      check("mrst_pkt",    32'(rx_packet), 0);
      check("mrst_data",   32'(rx_packet_data), 0);
      check("mrst_store",  32'(store_rx_packet_data), 0);
      check("mrst_count",  32'(rx_byte_count), 0);
      check("mrst_error",  32'(rx_error), 0);
      send_byte(8'h03);
      cycle();
      n_rst = 1'b1;
      send_byte(8'h04);
      repeat (2) cycle();
      check("mrst_no_store", 32'(store_cnt - s0), 0);
      check("mrst_idle", 32'(rcving), 0);
      check("exp_q_empty", 32'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
